serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_pkg.sv | 36 +++
 rtl/serial_frame_shreg.sv | 34 +++
 rtl/serial_frame_tx.sv | 101 ++++++++++
 tb/tb_serial_frame_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_pkg
// Brief   : Shared FSM states, frame constants and frame builder for
//           serial_frame_tx. Option macro: SERIAL_FRAME_TX_SYNC_HEADER_EN.
// Revision: 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_HDR    = 4'b1010;
    localparam logic [3:0] HDR_LEN     = 4'd4;
    localparam logic [3:0] PAYLOAD_LEN = 4'd8;

`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
    localparam int unsigned FRAME_LEN = 32'(HDR_LEN) + 32'(PAYLOAD_LEN);
`else
    localparam int unsigned FRAME_LEN = 32'(PAYLOAD_LEN);
`endif

    // Full frame as loaded into the shifter, first bit on the line in the MSB.
    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [7:0] data);
`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
        return {SYNC_HDR, data};
`else
        return data;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_shreg.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_shreg
// Brief   : Loadable MSB-first shift register; the MSB flop drives the line.
// Revision: 1.0 - initial release
// ============================================================================
module serial_frame_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_q;

    // Zeros shift in behind the frame, so the line returns to 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_tx
// Brief   : Byte-in, serial-out framer with optional 1010 sync header.
//           Option macro: SERIAL_FRAME_TX_SYNC_HEADER_EN.
// Revision: 1.0 - initial release
// ============================================================================
module serial_frame_tx
    import serial_frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out,
    output logic       busy,
    output logic       frame_done
);

`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
    localparam state_t c_FIRST_STATE = HEADER;
`else
    localparam state_t c_FIRST_STATE = PAYLOAD;
`endif

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       w_xfer;
    logic       w_shift;

    assign in_ready = (r_state == IDLE);
    assign w_xfer   = in_valid && in_ready;
    assign w_shift  = !in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_xfer) begin
                        r_state <= c_FIRST_STATE;
                        r_busy  <= 1'b1;
                    end
                end
`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
                HEADER: begin
                    if (r_cnt == HDR_LEN - 4'd1) begin
                        r_state <= PAYLOAD;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
`endif
                PAYLOAD: begin
                    if (r_cnt == PAYLOAD_LEN - 4'd1) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        // Next edge puts bit0 on the line.
                        if (r_cnt == PAYLOAD_LEN - 4'd2) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    serial_frame_shreg #(
        .WIDTH (FRAME_LEN)
    ) u_shreg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_xfer),
        .i_shift (w_shift),
        .i_data  (frame_word(in_data)),
        .o_msb   (out)
    );

    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_frame_tx
// Brief   : Self-checking bench for serial_frame_tx against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
    localparam int HL = 4;
`else
    localparam int HL = 0;
`endif
    localparam int FL = HL + 8;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out;
    logic       busy;
    logic       frame_done;

    int          total;
    int          bad;
    int          cyc;
    int          done_cyc;
    logic [11:0] obs;

    serial_frame_tx dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Line bit k of a frame carrying byte b: optional 1010 header, then b MSB-first.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        logic [3:0] hdr;
        hdr = 4'b1010;
        if (k < HL) return hdr[3-k];
        return b[7-(k-HL)];
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit mid_rand,
                              input logic mid_v, input logic [7:0] mid_d,
                              input logic nv, input logic [7:0] nd);
        logic eb;
        logic ed;
        in_valid = 1'b1;
        in_data  = b;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready byte=%h in_ready=%b want 1", b, in_ready);
        end
        @(posedge clk);
        obs = '0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            obs[FL-1-k] = out;
            eb = exp_bit(b, k);
            ed = (k == FL - 1);
            if (ed) done_cyc = cyc;
            total++;
            if (out !== eb || frame_done !== ed || busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL frame_bit byte=%h k=%0d got out=%b fd=%b busy=%b rdy=%b want out=%b fd=%b busy=1 rdy=0",
                         b, k, out, frame_done, busy, in_ready, eb, ed);
            end
            if (ed) begin
                in_valid = nv;
                in_data  = nd;
            end else if (mid_rand) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end else begin
                in_valid = mid_v;
                in_data  = mid_d;
            end
        end
        @(negedge clk);
        total++;
        if (out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_gap byte=%h got out=%b fd=%b busy=%b rdy=%b want 0 0 0 1",
                     b, out, frame_done, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_state got out=%b fd=%b busy=%b rdy=%b want 0 0 0 1",
                         out, frame_done, busy, in_ready);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got rdy=%b busy=%b out=%b want 1 0 0", in_ready, busy, out);
        end
    endtask

    task automatic test_spec_vector();
        logic [11:0] want;
`ifdef SERIAL_FRAME_TX_SYNC_HEADER_EN
        want = 12'b1010_1010_0101;
        send_frame(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
`else
        want = 12'b0000_0011_1100;
        send_frame(8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
`endif
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL spec_vector got %b want %b", obs, want);
        end
    endtask

    task automatic test_ignore_busy();
        send_frame(8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
        total++;
        if (obs[7:0] !== 8'hFF) begin
            bad++;
            $display("FAIL ignore_busy_payload got %h want ff", obs[7:0]);
        end
        send_frame(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        int d1;
        send_frame(8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 8'h7E);
        d1 = done_cyc;
        send_frame(8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 8'h00);
        total++;
        if (done_cyc - d1 !== FL + 1) begin
            bad++;
            $display("FAIL b2b_period got %0d want %0d", done_cyc - d1, FL + 1);
        end
    endtask

    task automatic test_midframe_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        for (int k = 0; k <= HL + 4; k++) begin
            @(negedge clk);
            total++;
            if (out !== exp_bit(8'hA5, k) || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL abort_prefix k=%0d got out=%b fd=%b want out=%b fd=0",
                         k, out, frame_done, exp_bit(8'hA5, k));
            end
            in_valid = 1'b0;
        end
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_reset got out=%b fd=%b busy=%b rdy=%b want 0 0 0 1",
                         out, frame_done, busy, in_ready);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (out !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_recover got out=%b fd=%b busy=%b rdy=%b want 0 0 0 1",
                         out, frame_done, busy, in_ready);
            end
        end
        send_frame(8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] bytes [0:24];
        int         gap;
        for (int i = 0; i < 25; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 25; i++) begin
            gap = (i == 24) ? 1 : int'($urandom_range(0, 3));
            send_frame(bytes[i], 1'b1, 1'b0, 8'h00, (gap == 0),
                       (i == 24) ? 8'h00 : bytes[(i + 1) % 25]);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                total++;
                if (out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL random_gap i=%0d got out=%b busy=%b rdy=%b fd=%b want 0 0 1 0",
                             i, out, busy, in_ready, frame_done);
                end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        done_cyc = 0;
        obs      = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_spec_vector();
        test_ignore_busy();
        test_back_to_back();
        test_midframe_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
